// File: rtl/pwm_channel_bank.sv
// N-channel PWM bank: shadow duties are scaled by a global intensity with one shared
// shift-add multiplier, then applied to all channels together on a period wrap.
module pwm_channel_lane #(
  parameter int WIDTH = 8,
  parameter int OFFS  = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_cnt,
  input  logic [WIDTH-1:0] i_duty,
  output logic             o_pwm
);
  localparam logic [WIDTH:0] P   = (WIDTH+1)'((1 << WIDTH) - 1);
  localparam logic [WIDTH:0] SUB = (WIDTH+1)'(OFFS);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_ph;
  logic           r_pwm;

  // offset never exceeds P, so the sum lies in [0, 2P) and one subtract wraps it mod P
  assign w_sum = {1'b0, i_cnt} + P - SUB;
  assign w_ph  = (w_sum >= P) ? w_sum - P : w_sum;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_pwm <= 1'b0;
    else          r_pwm <= (w_ph < {1'b0, i_duty});

  assign o_pwm = r_pwm;
endmodule

module pwm_channel_bank #(
  parameter  int CHANNELS = 4,
  parameter  int WIDTH    = 8,
  parameter  int PRESC    = 4,
  parameter  int STAGGER  = 0,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wr_valid,
  output logic                o_wr_ready,
  input  logic [CW-1:0]       i_wr_chan,
  input  logic [WIDTH-1:0]    i_wr_duty,
  input  logic                i_commit,
  input  logic [WIDTH-1:0]    i_lint,
  output logic                o_busy,
  output logic                o_period_start,
  output logic [CHANNELS-1:0] o_pwm_out
);
  localparam int P   = (1 << WIDTH) - 1;
  localparam int OFS = (STAGGER != 0) ? P / CHANNELS : 0;
  localparam int PSW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int BW  = $clog2(WIDTH + 1);
  localparam int PW  = 2 * WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_SCALE, S_PEND} state_t;

  state_t                         r_state, w_nxt;
  logic [PSW-1:0]                 r_psc;
  logic [WIDTH-1:0]               r_cnt;
  logic                           w_tick, w_wrap, w_ready, w_last;
  logic [WIDTH:0]                 r_mul;
  logic [PW-1:0]                  r_acc, w_pp, w_acc;
  logic [BW-1:0]                  r_bit;
  logic [CW-1:0]                  r_ch;
  logic [CHANNELS-1:0][WIDTH-1:0] r_shadow, r_staged, r_active;
  logic [CHANNELS-1:0]            w_pwm;

  assign w_tick = (r_psc == PSW'(PRESC - 1));
  assign w_wrap = w_tick && (r_cnt == WIDTH'(P - 1));

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_psc <= '0;
      r_cnt <= '0;
    end else begin
      r_psc <= w_tick ? '0 : r_psc + PSW'(1);
      if (w_tick) r_cnt <= (r_cnt == WIDTH'(P - 1)) ? '0 : r_cnt + WIDTH'(1);
    end

  assign w_ready = (r_state == S_IDLE);
  assign w_last  = (r_bit == BW'(WIDTH)) && (r_ch == CW'(CHANNELS - 1));

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_nxt;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_commit) w_nxt = S_SCALE;
      S_SCALE: if (w_last)   w_nxt = S_PEND;
      S_PEND:  if (w_wrap)   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // one multiplier bit per clock, LSB first; WIDTH+1 clocks per channel
  assign w_pp  = r_mul[r_bit] ? (PW'(r_shadow[r_ch]) << r_bit) : '0;
  assign w_acc = r_acc + w_pp;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_shadow <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        if (i_wr_valid && w_ready && (i_wr_chan == CW'(i))) r_shadow[i] <= i_wr_duty;
    end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_mul    <= '0;
      r_acc    <= '0;
      r_bit    <= '0;
      r_ch     <= '0;
      r_staged <= '0;
      r_active <= '0;
    end else begin
      if (w_ready && i_commit) begin
        r_mul <= {1'b0, i_lint} + (WIDTH+1)'(1);
        r_acc <= '0;
        r_bit <= '0;
        r_ch  <= '0;
      end else if (r_state == S_SCALE) begin
        if (r_bit == BW'(WIDTH)) begin
          r_staged[r_ch] <= WIDTH'(w_acc >> WIDTH);
          r_acc          <= '0;
          r_bit          <= '0;
          r_ch           <= r_ch + CW'(1);
        end else begin
          r_acc <= w_acc;
          r_bit <= r_bit + BW'(1);
        end
      end
      if ((r_state == S_PEND) && w_wrap) r_active <= r_staged;
    end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    pwm_channel_lane #(.WIDTH(WIDTH), .OFFS(g * OFS)) u_lane (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_cnt  (r_cnt),
      .i_duty (r_active[g]),
      .o_pwm  (w_pwm[g])
    );
  end

  assign o_wr_ready     = w_ready;
  assign o_busy         = (r_state != S_IDLE);
  assign o_period_start = w_wrap;
  assign o_pwm_out      = w_pwm;
endmodule

// File: tb/tb_pwm_channel_bank.sv
// Scoreboard bench: two banks (aligned and staggered) share stimulus; a monitor measures
// per-channel high time and rising-edge position over each full PWM period.
module tb_pwm_channel_bank;
  typedef logic [3:0][7:0] exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0, commit = 1'b0;
  logic [1:0] wr_chan = '0;
  logic [7:0] wr_duty = '0, lint = '0;
  logic       rdy_a, busy_a, ps_a, rdy_b, busy_b, ps_b;
  logic [3:0] pwm_a, pwm_b;

  int   n_cmp = 0, n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pwm_channel_bank #(.CHANNELS(4), .WIDTH(8), .PRESC(4), .STAGGER(0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wr_valid), .o_wr_ready(rdy_a),
    .i_wr_chan(wr_chan), .i_wr_duty(wr_duty), .i_commit(commit), .i_lint(lint),
    .o_busy(busy_a), .o_period_start(ps_a), .o_pwm_out(pwm_a));

  pwm_channel_bank #(.CHANNELS(4), .WIDTH(8), .PRESC(4), .STAGGER(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wr_valid), .o_wr_ready(rdy_b),
    .i_wr_chan(wr_chan), .i_wr_duty(wr_duty), .i_commit(commit), .i_lint(lint),
    .o_busy(busy_b), .o_period_start(ps_b), .o_pwm_out(pwm_b));

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // monitor: a window opens on a period_start while an expectation is queued and
  // closes on the next one, covering exactly one PWM period of samples
  initial begin
    int   cnt_a[4], cnt_b[4], rise_a[4], rise_b[4], idx;
    logic [3:0] prev_a, prev_b;
    bit   armed;
    exp_t e;
    armed = 0; idx = 0; prev_a = '0; prev_b = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        armed = 0; prev_a = '0; prev_b = '0;
      end else begin
        if (armed) begin
          for (int i = 0; i < 4; i++) begin
            if (pwm_a[i]) cnt_a[i]++;
            if (pwm_b[i]) cnt_b[i]++;
            if (pwm_a[i] && !prev_a[i] && rise_a[i] < 0) rise_a[i] = idx;
            if (pwm_b[i] && !prev_b[i] && rise_b[i] < 0) rise_b[i] = idx;
          end
          idx++;
        end
        prev_a = pwm_a;
        prev_b = pwm_b;
        if (ps_a) begin
          if (armed) begin
            e = sb.pop_front();
            for (int i = 0; i < 4; i++) begin
              int d;
              d = int'(e[i]);
              chk($sformatf("high_a[%0d]", i), cnt_a[i], d * 4);
              chk($sformatf("high_b[%0d]", i), cnt_b[i], d * 4);
              chk($sformatf("rise_a[%0d]", i), rise_a[i], (d == 0 || d == 255) ? -1 : 1);
              chk($sformatf("rise_b[%0d]", i), rise_b[i], (d == 0 || d == 255) ? -1 : 4 * i * 63 + 1);
            end
            armed = 0;
          end
          if (sb.size() != 0) begin
            armed = 1; idx = 0;
            for (int i = 0; i < 4; i++) begin
              cnt_a[i] = 0; cnt_b[i] = 0; rise_a[i] = -1; rise_b[i] = -1;
            end
          end
        end
      end
    end
  end

  task automatic wr(input logic [1:0] ch, input logic [7:0] d);
    @(negedge clk); wr_valid = 1'b1; wr_chan = ch; wr_duty = d;
    @(negedge clk); wr_valid = 1'b0;
  endtask

  task automatic wait_ps();
    int n = 0;
    do begin @(negedge clk); n++; end while (!ps_a && n < 3000);
    if (!ps_a) chk("period_start_timeout", 0, 1);
  endtask

  // commit m clocks after a period_start, optionally holding a write through busy
  task automatic commit_run(input int m, input logic [1:0] ch, input logic [7:0] d,
                            input logic [7:0] l, input bit hold, input logic [1:0] hch,
                            input logic [7:0] hd, input int exp_busy, input exp_t e);
    int nb = 0, nrdy = 0;
    wait_ps();
    repeat (m) @(negedge clk);
    wr_valid = 1'b1; wr_chan = ch; wr_duty = d; commit = 1'b1; lint = l;
    @(negedge clk);
    commit = 1'b0; wr_valid = hold; wr_chan = hch; wr_duty = hd;
    while (busy_a && nb < 4000) begin
      nb++;
      if (rdy_a) nrdy++;
      @(negedge clk);
    end
    chk("busy_len", nb, exp_busy);
    chk("ready_while_busy", nrdy, 0);
    if (hold) begin
      chk("ready_after_busy", int'(rdy_a), 1);
      @(negedge clk); wr_valid = 1'b0;
    end
    sb.push_back(e);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_pwm_a", int'(pwm_a), 0);
    chk("rst_pwm_b", int'(pwm_b), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_ready", int'(rdy_a), 1);
    chk("rst_period_start", int'(ps_a), 0);
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ps_a && n < 3000);
    chk("first_period_start", n, 1019);
    n = 0;
    do begin @(negedge clk); n++; end while (!ps_a && n < 3000);
    chk("period_len", n, 1020);

    commit_run(0, 2'd0, 8'd128, 8'd255, 0, 2'd0, 8'd0, 1020, {8'd0, 8'd0, 8'd0, 8'd128});
    commit_run(0, 2'd1, 8'd200, 8'd127, 0, 2'd0, 8'd0, 1020, {8'd0, 8'd0, 8'd100, 8'd64});
    commit_run(0, 2'd1, 8'd255, 8'd255, 0, 2'd0, 8'd0, 1020, {8'd0, 8'd0, 8'd255, 8'd128});
    commit_run(0, 2'd2, 8'd50, 8'd255, 0, 2'd0, 8'd0, 1020, {8'd0, 8'd50, 8'd255, 8'd128});
    commit_run(10, 2'd2, 8'd180, 8'd255, 1, 2'd3, 8'd64, 1010, {8'd0, 8'd180, 8'd255, 8'd128});
    commit_run(0, 2'd1, 8'd0, 8'd255, 0, 2'd0, 8'd0, 1020, {8'd64, 8'd180, 8'd0, 8'd128});

    n = 0;
    while (sb.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    chk("drain_before_reset", sb.size(), 0);
    wait_ps();
    wr_valid = 1'b1; wr_chan = 2'd0; wr_duty = 8'd99; commit = 1'b1; lint = 8'd0;
    @(negedge clk); commit = 1'b0; wr_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midscale_rst_pwm_a", int'(pwm_a), 0);
    chk("midscale_rst_pwm_b", int'(pwm_b), 0);
    chk("midscale_rst_busy", int'(busy_a), 0);
    chk("midscale_rst_ready", int'(rdy_a), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    wr(2'd0, 8'd128);
    wr(2'd2, 8'd60);
    commit_run(0, 2'd1, 8'd0, 8'd200, 0, 2'd0, 8'd0, 1020, {8'd0, 8'd47, 8'd0, 8'd100});

    wr(2'd0, 8'd64);
    wr(2'd1, 8'd64);
    wr(2'd2, 8'd64);
    commit_run(1010, 2'd3, 8'd64, 8'd255, 0, 2'd0, 8'd0, 1030, {8'd64, 8'd64, 8'd64, 8'd64});

    n = 0;
    while (sb.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    chk("final_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
